dcache_memarray: RTL and testbench
==================================

Name: dcache_memarray

Overview:
Parametrised data-cache storage array with generic byte-lane banking, per-word dirty tracking and a built-in flush scanner.
- CPU port: single-cycle-latency reads and byte-enabled writes.
- Fill port: refill writes from the memory side.
- Flush scanner: on request, walks the whole array and streams every dirty word out over a valid/ready handshake to the flush controller.
- Sits between the dcache tag/control logic and the bus interface, replacing the fixed 4x8-bit memblock.

Parameters:
- DATABITS, 32: word width; must be a multiple of BANKNUM (elaboration error otherwise).
- ADDRBITS, 5: word address width.
- MEMSIZE, 2**ADDRBITS: words per array.
- BANKNUM, 4: number of independently write-enabled lanes.
- BANKDATABITS, DATABITS/BANKNUM: bits per lane (derived, not overridden).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- addr  in  ADDRBITS  CPU word address.
- data_in  in  DATABITS  CPU write data.
- we  in  1  CPU write strobe.
- byteenable  in  BANKNUM  CPU lane enables.
- re  in  1  CPU read strobe.
- data_out  out  DATABITS  CPU read data.
- data_valid  out  1  read data valid.
- data_err  out  1  read parity error (see Optional Feature).
- busy  out  1  flush scan in progress; CPU and fill accesses are ignored.
- fill_we  in  1  refill write strobe.
- fill_addr  in  ADDRBITS  refill address.
- fill_data  in  DATABITS  refill data.
- fill_byteenable  in  BANKNUM  refill lane enables.
- flush_start  in  1  single-cycle pulse that starts a scan.
- flush_valid  out  1  dirty word presented.
- flush_ready  in  1  flush controller accepts the word.
- flush_addr_out  out  ADDRBITS  address of the presented word.
- flush_data_out  out  DATABITS  data of the presented word.
- flush_done  out  1  single-cycle pulse when the scan completes.

Behaviour:
- Reset (asynchronous):
  - State IDLE; all dirty bits cleared.
  - data_out, data_valid, data_err, busy, flush_valid, flush_addr_out, flush_data_out and flush_done all 0.
  - RAM contents are not reset.
  - Reset asserted mid-scan aborts the scan: no flush_done, and dirty information is lost.
- Write arbitration in IDLE: fill_we has priority over we.
  - Lane i is written when (fill_we & fill_byteenable[i]) or (!fill_we & we & byteenable[i]).
  - A CPU write with any byteenable bit set marks dirty[addr] = 1.
  - A fill write clears dirty[fill_addr], including when fill_byteenable is 0.
  - A CPU write with byteenable = 0 writes nothing and leaves dirty unchanged.
- Reads:
  - re in cycle N gives data_out and data_valid = 1 in cycle N+1. data_valid is a single-cycle pulse; data_out holds its last value otherwise.
  - Reads are read-first: re and we to the same address in one cycle return the old data.
  - A read is ignored when fill_we is high in the same cycle (the array is single-ported); no data_valid follows.
- Scanner FSM states: IDLE, SCAN, EMIT, DONE. The index register idx is ADDRBITS wide.
  - IDLE: flush_start -> SCAN with idx = 0. busy = 1 from the next cycle.
  - SCAN, dirty[idx] = 0:
    - idx == MEMSIZE-1 -> DONE.
    - otherwise idx+1, stay in SCAN.
  - SCAN, dirty[idx] = 1: issue a RAM read at idx -> EMIT. The RAM output is latched into flush_data_out on entry.
  - EMIT: flush_valid = 1; flush_addr_out and flush_data_out are held stable until accepted.
  - EMIT, flush_ready = 1: clear dirty[idx], deassert flush_valid the following cycle.
    - idx == MEMSIZE-1 -> DONE.
    - otherwise idx+1 -> SCAN.
  - DONE: flush_done = 1 for one cycle, busy = 0 from the next cycle -> IDLE.
- While busy:
  - we, fill_we, re and flush_start are all ignored.
  - A flush_start in the same cycle as a CPU/fill write in IDLE: the write completes first, then the scan starts.
- Timing: a clean array completes a scan in MEMSIZE+2 cycles after flush_start. idx never wraps past MEMSIZE-1.

Optional Feature:
Macro: DCACHE_PARITY_EN.
- Defined:
  - Each lane stores one extra even-parity bit, written with the lane data.
  - data_err = 1 alongside data_valid when any lane's parity mismatches on a CPU read.
  - Scanner reads do not assert data_err.
- Undefined: no parity storage; data_err is tied to 0.

Decomposition:
- Package dcache_pkg holds:
  - The scanner state enum (IDLE, SCAN, EMIT, DONE).
  - A lane-width helper function.
  - An elaboration check that DATABITS % BANKNUM == 0.
- One sub-module, dcache_spram_bank: a generic single-port synchronous RAM of width BANKDATABITS (+1 with parity) and depth MEMSIZE.
  - It is instantiated BANKNUM times in a generate loop.
- Dirty bits are a MEMSIZE-bit flop vector in the top module.

Test Plan:
- Write addr 3 = 0xDEADBEEF with byteenable 1111, then write addr 3 = 0x000000AA with byteenable 0001, then re at 3 -> data_out 0xDEADBEAA, data_valid exactly one cycle later.
- Same-cycle we (0x11111111) and re at addr 5, where addr 5 holds 0x22222222 -> data_out 0x22222222; the next read returns 0x11111111.
- CPU-write addrs 2 and 30, fill-write addr 2, then flush_start with flush_ready = 1 -> exactly one beat (addr 30), then flush_done; a second scan emits nothing and finishes in 34 cycles.
- Dirty addr 7 with flush_ready held 0 for 5 cycles -> flush_valid and the data stay stable; accept on the 6th cycle, dirty[7] cleared, busy drops the cycle after flush_done.
- Assert reset_n = 0 during EMIT -> flush_valid, busy and data_valid go 0 immediately; after release a scan emits nothing.
- With DCACHE_PARITY_EN, force a lane bit flip in bank 2 via hierarchical deposit -> data_err = 1 with data_valid; without the macro, data_err stays 0.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and helpers for the dcache storage array.
//   scan_state_t   : flush scanner states
//   lane_bits()    : width of one byte lane for a given word width / lane count
//   lane_split_ok(): true when the word splits evenly into lanes
//   LANE_PAR_BITS  : extra stored bits per lane (1 when DCACHE_PARITY_EN is defined)
package dcache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } scan_state_t;

`ifdef DCACHE_PARITY_EN
    localparam int LANE_PAR_BITS = 1;
`else
    localparam int LANE_PAR_BITS = 0;
`endif

    function automatic int lane_bits(input int databits, input int banknum);
        return databits / banknum;
    endfunction

    function automatic bit lane_split_ok(input int databits, input int banknum);
        return (banknum > 0) && ((databits % banknum) == 0);
    endfunction

endpackage

// File: rtl/dcache_spram_bank.sv
// Generic single-port synchronous RAM, read-first. One instance holds one lane.
// Ports:
//   clk   : clock
//   en    : access enable (read and/or write)
//   we    : write enable (only with en)
//   addr  : word address
//   wdata : write data
//   rdata : registered read data, updated only on enabled accesses
// Contents are not reset.
module dcache_spram_bank #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dcache_memarray.sv
// Data-cache storage array: lane-banked RAM, per-word dirty bits, flush scanner.
// Ports:
//   clk, reset_n                        : clock, async active-low reset
//   addr/data_in/we/byteenable/re       : CPU access (1-cycle read latency)
//   data_out/data_valid/data_err        : CPU read response
//   busy                                : scan in progress, all accesses ignored
//   fill_we/fill_addr/fill_data/
//   fill_byteenable                     : refill writes (priority over CPU)
//   flush_start                         : pulse to start a dirty scan
//   flush_valid/flush_ready/
//   flush_addr_out/flush_data_out       : dirty word stream
//   flush_done                          : pulse when the scan completes
// Optional: DCACHE_PARITY_EN adds an even-parity bit per lane and drives data_err.
//
// state | meaning
// IDLE  | serving CPU/fill accesses, waiting for flush_start
// SCAN  | testing dirty[idx]; reads the RAM when dirty
// EMIT  | dirty word presented, waiting for flush_ready
// DONE  | flush_done pulse, busy released next cycle
module dcache_memarray
    import dcache_pkg::*;
#(
    parameter int DATABITS = 32,
    parameter int ADDRBITS = 5,
    parameter int MEMSIZE  = 2**ADDRBITS,
    parameter int BANKNUM  = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDRBITS-1:0] addr,
    input  logic [DATABITS-1:0] data_in,
    input  logic                we,
    input  logic [BANKNUM-1:0]  byteenable,
    input  logic                re,
    output logic [DATABITS-1:0] data_out,
    output logic                data_valid,
    output logic                data_err,
    output logic                busy,
    input  logic                fill_we,
    input  logic [ADDRBITS-1:0] fill_addr,
    input  logic [DATABITS-1:0] fill_data,
    input  logic [BANKNUM-1:0]  fill_byteenable,
    input  logic                flush_start,
    output logic                flush_valid,
    input  logic                flush_ready,
    output logic [ADDRBITS-1:0] flush_addr_out,
    output logic [DATABITS-1:0] flush_data_out,
    output logic                flush_done
);

    localparam int BANKDATABITS = lane_bits(DATABITS, BANKNUM);
    localparam int LANE_W       = BANKDATABITS + LANE_PAR_BITS;
    localparam logic [ADDRBITS-1:0] IDX_LAST = ADDRBITS'(MEMSIZE - 1);

    if (!lane_split_ok(DATABITS, BANKNUM)) begin : g_bad_split
        $error("dcache_memarray: DATABITS must be a multiple of BANKNUM");
    end

    scan_state_t         state;
    logic [ADDRBITS-1:0] idx;
    logic [MEMSIZE-1:0]  dirty;
    logic                idle;
    logic                cpu_rd;
    logic                scan_rd;
    logic                emit_take;
    logic [BANKNUM-1:0]  lane_we;
    logic [ADDRBITS-1:0] ram_addr;
    logic [DATABITS-1:0] ram_wdata;
    logic [DATABITS-1:0] ram_rdata;
    logic [DATABITS-1:0] data_hold;
    logic [DATABITS-1:0] flush_hold;

    assign idle      = (state == ST_IDLE);
    assign cpu_rd    = idle & re & ~fill_we;
    assign scan_rd   = (state == ST_SCAN) & dirty[idx];
    assign emit_take = (state == ST_EMIT) & flush_ready;
    assign ram_addr  = !idle ? idx : (fill_we ? fill_addr : addr);
    assign ram_wdata = fill_we ? fill_data : data_in;

    always_comb begin
        lane_we = '0;
        if (idle) begin
            if (fill_we) begin
                lane_we = fill_byteenable;
            end else if (we) begin
                lane_we = byteenable;
            end
        end
    end

`ifdef DCACHE_PARITY_EN
    logic [BANKNUM-1:0] lane_perr;
`endif

    for (genvar b = 0; b < BANKNUM; b++) begin : g_bank
        logic [BANKDATABITS-1:0] wlane;
        logic [LANE_W-1:0]       wword;
        logic [LANE_W-1:0]       rword;

        assign wlane = ram_wdata[b*BANKDATABITS +: BANKDATABITS];
`ifdef DCACHE_PARITY_EN
        assign wword        = {^wlane, wlane};
        // Even parity over data plus stored bit must reduce to 0.
        assign lane_perr[b] = ^rword;
`else
        assign wword = wlane;
`endif
        assign ram_rdata[b*BANKDATABITS +: BANKDATABITS] = rword[BANKDATABITS-1:0];

        dcache_spram_bank #(
            .WIDTH (LANE_W),
            .DEPTH (MEMSIZE),
            .AW    (ADDRBITS)
        ) u_bank (
            .clk   (clk),
            .en    (lane_we[b] | cpu_rd | scan_rd),
            .we    (lane_we[b]),
            .addr  (ram_addr),
            .wdata (wword),
            .rdata (rword)
        );
    end

    // The RAM is untouched while a word is presented, so its output is the
    // flush data for the whole EMIT stay; the hold registers keep the last
    // value once the RAM output moves on.
    assign data_out       = data_valid  ? ram_rdata : data_hold;
    assign flush_data_out = flush_valid ? ram_rdata : flush_hold;

`ifdef DCACHE_PARITY_EN
    assign data_err = data_valid & (|lane_perr);
`else
    assign data_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_valid <= 1'b0;
            data_hold  <= '0;
            flush_hold <= '0;
        end else begin
            data_valid <= cpu_rd;
            if (data_valid) begin
                data_hold <= ram_rdata;
            end
            if (emit_take) begin
                flush_hold <= ram_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dirty <= '0;
        end else if (idle) begin
            if (fill_we) begin
                dirty[fill_addr] <= 1'b0;
            end else if (we && (|byteenable)) begin
                dirty[addr] <= 1'b1;
            end
        end else if (emit_take) begin
            dirty[idx] <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            idx            <= '0;
            busy           <= 1'b0;
            flush_valid    <= 1'b0;
            flush_addr_out <= '0;
            flush_done     <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (flush_start) begin
                        state <= ST_SCAN;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (dirty[idx]) begin
                        state          <= ST_EMIT;
                        flush_valid    <= 1'b1;
                        flush_addr_out <= idx;
                    end else if (idx == IDX_LAST) begin
                        state      <= ST_DONE;
                        flush_done <= 1'b1;
                    end else begin
                        idx <= idx + ADDRBITS'(1);
                    end
                end
                ST_EMIT: begin
                    if (flush_ready) begin
                        flush_valid <= 1'b0;
                        if (idx == IDX_LAST) begin
                            state      <= ST_DONE;
                            flush_done <= 1'b1;
                        end else begin
                            idx   <= idx + ADDRBITS'(1);
                            state <= ST_SCAN;
                        end
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_memarray.sv
// Scoreboard bench for dcache_memarray: stimulus pushes expected read and flush
// responses into queues, a monitor pops and compares when the DUT presents them.
module tb_dcache_memarray;

    logic        clk;
    logic        reset_n;
    logic [4:0]  addr;
    logic [31:0] data_in;
    logic        we;
    logic [3:0]  byteenable;
    logic        re;
    logic [31:0] data_out;
    logic        data_valid;
    logic        data_err;
    logic        busy;
    logic        fill_we;
    logic [4:0]  fill_addr;
    logic [31:0] fill_data;
    logic [3:0]  fill_byteenable;
    logic        flush_start;
    logic        flush_valid;
    logic        flush_ready;
    logic [4:0]  flush_addr_out;
    logic [31:0] flush_data_out;
    logic        flush_done;

    dcache_memarray u_dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .addr            (addr),
        .data_in         (data_in),
        .we              (we),
        .byteenable      (byteenable),
        .re              (re),
        .data_out        (data_out),
        .data_valid      (data_valid),
        .data_err        (data_err),
        .busy            (busy),
        .fill_we         (fill_we),
        .fill_addr       (fill_addr),
        .fill_data       (fill_data),
        .fill_byteenable (fill_byteenable),
        .flush_start     (flush_start),
        .flush_valid     (flush_valid),
        .flush_ready     (flush_ready),
        .flush_addr_out  (flush_addr_out),
        .flush_data_out  (flush_data_out),
        .flush_done      (flush_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } rd_exp_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } fl_exp_t;

    rd_exp_t rd_q[$];
    fl_exp_t fl_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    int n_beats  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event seen with no expectation queued", name);
    endtask

    // Monitor: samples 3 time units after each rising edge.
    always @(posedge clk) begin
        rd_exp_t re_e;
        fl_exp_t fl_e;
        #3;
        if (reset_n) begin
            if (data_valid) begin
                if (rd_q.size() == 0) begin
                    fail_event("unexpected_read_valid");
                end else begin
                    re_e = rd_q.pop_front();
                    chk("read_data", 64'(data_out), 64'(re_e.data));
                    chk("read_err", 64'(data_err), 64'(re_e.err));
                    chk("read_latency_cycle", 64'(cyc), 64'(re_e.cyc));
                end
            end
            if (flush_valid && flush_ready) begin
                n_beats++;
                if (fl_q.size() == 0) begin
                    fail_event("unexpected_flush_beat");
                end else begin
                    fl_e = fl_q.pop_front();
                    chk("flush_addr", 64'(flush_addr_out), 64'(fl_e.addr));
                    chk("flush_data", 64'(flush_data_out), 64'(fl_e.data));
                end
            end
            if (flush_done) n_done++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        addr = a; data_in = d; byteenable = be; we = 1'b1;
        tick();
        we = 1'b0; byteenable = '0;
    endtask

    task automatic fill_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        fill_addr = a; fill_data = d; fill_byteenable = be; fill_we = 1'b1;
        tick();
        fill_we = 1'b0; fill_byteenable = '0;
    endtask

    task automatic cpu_rd(input logic [4:0] a, input logic [31:0] d, input logic e);
        addr = a; re = 1'b1;
        rd_q.push_back('{data: d, err: e, cyc: cyc + 1});
        tick();
        re = 1'b0;
    endtask

    // Pulses flush_start and counts edges until busy is seen low again.
    task automatic run_scan(output int n);
        flush_start = 1'b1;
        n = 0;
        do begin
            tick();
            flush_start = 1'b0;
            n++;
        end while (busy && n < 200);
        if (busy) chk("scan_timeout_busy", 64'(busy), 64'(0));
    endtask

    int n, d0, b0;

    initial begin
        reset_n = 1'b0; addr = '0; data_in = '0; we = 1'b0; byteenable = '0; re = 1'b0;
        fill_we = 1'b0; fill_addr = '0; fill_data = '0; fill_byteenable = '0;
        flush_start = 1'b0; flush_ready = 1'b0;
        #2;
        chk("rst_data_out", 64'(data_out), 64'(0));
        chk("rst_data_valid", 64'(data_valid), 64'(0));
        chk("rst_data_err", 64'(data_err), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_flush_valid", 64'(flush_valid), 64'(0));
        chk("rst_flush_addr", 64'(flush_addr_out), 64'(0));
        chk("rst_flush_data", 64'(flush_data_out), 64'(0));
        chk("rst_flush_done", 64'(flush_done), 64'(0));
        tick(); tick();
        reset_n = 1'b1;
        tick();

        // Byte-lane merge and read latency.
        cpu_wr(5'd3, 32'hDEADBEEF, 4'b1111);
        cpu_wr(5'd3, 32'h000000AA, 4'b0001);
        cpu_rd(5'd3, 32'hDEADBEAA, 1'b0);
        fill_wr(5'd6, 32'h66666666, 4'b1111);
        chk("data_out_hold", 64'(data_out), 64'h00000000DEADBEAA);
        chk("data_valid_pulse", 64'(data_valid), 64'(0));

        // Read-first on same-cycle write.
        cpu_wr(5'd5, 32'h22222222, 4'b1111);
        addr = 5'd5; data_in = 32'h11111111; byteenable = 4'b1111; we = 1'b1; re = 1'b1;
        rd_q.push_back('{data: 32'h22222222, err: 1'b0, cyc: cyc + 1});
        tick();
        we = 1'b0; re = 1'b0; byteenable = '0;
        cpu_rd(5'd5, 32'h11111111, 1'b0);

        // Read colliding with a fill write is dropped.
        addr = 5'd5; re = 1'b1;
        fill_addr = 5'd8; fill_data = 32'h88888888; fill_byteenable = 4'b1111; fill_we = 1'b1;
        tick();
        re = 1'b0; fill_we = 1'b0; fill_byteenable = '0;
        tick();
        chk("read_dropped_on_fill", 64'(data_valid), 64'(0));
        cpu_rd(5'd8, 32'h88888888, 1'b0);

        // Fill with no lanes enabled clears dirty and writes nothing.
        fill_wr(5'd3, 32'hFFFFFFFF, 4'b0000);
        fill_wr(5'd5, 32'hFFFFFFFF, 4'b0000);
        cpu_rd(5'd5, 32'h11111111, 1'b0);

        // Scan: only addr 30 remains dirty.
        cpu_wr(5'd2, 32'hA5A50002, 4'b1111);
        cpu_wr(5'd30, 32'h30303030, 4'b1111);
        fill_wr(5'd2, 32'h0F0F0F0F, 4'b1111);
        cpu_wr(5'd12, 32'hFFFFFFFF, 4'b0000);
        fl_q.push_back('{addr: 5'd30, data: 32'h30303030});
        flush_ready = 1'b1;
        d0 = n_done; b0 = n_beats;
        run_scan(n);
        chk("scan1_cycles", 64'(n), 64'(35));
        chk("scan1_beats", 64'(n_beats - b0), 64'(1));
        chk("scan1_done_pulses", 64'(n_done - d0), 64'(1));
        cpu_rd(5'd2, 32'h0F0F0F0F, 1'b0);

        // Clean scan with accesses and flush_start held while busy.
        d0 = n_done; b0 = n_beats;
        flush_start = 1'b1;
        n = 0;
        do begin
            tick();
            if (n == 0) begin
                addr = 5'd9; data_in = 32'h99999999; byteenable = 4'b1111;
                we = 1'b1; re = 1'b1;
                fill_addr = 5'd9; fill_data = 32'h99999999; fill_byteenable = 4'b1111;
                fill_we = 1'b1;
            end
            n++;
        end while (busy && n < 200);
        we = 1'b0; re = 1'b0; fill_we = 1'b0; flush_start = 1'b0;
        byteenable = '0; fill_byteenable = '0;
        chk("scan2_cycles", 64'(n), 64'(34));
        chk("scan2_beats", 64'(n_beats - b0), 64'(0));
        chk("scan2_done_pulses", 64'(n_done - d0), 64'(1));

        // Write and flush_start together; backpressure for 5 cycles.
        flush_ready = 1'b0;
        fl_q.push_back('{addr: 5'd7, data: 32'h77AA55CC});
        addr = 5'd7; data_in = 32'h77AA55CC; byteenable = 4'b1111; we = 1'b1; flush_start = 1'b1;
        tick();
        we = 1'b0; byteenable = '0; flush_start = 1'b0;
        n = 0;
        while (!flush_valid && n < 100) begin tick(); n++; end
        chk("emit7_reached", 64'(flush_valid), 64'(1));
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 64'(flush_valid), 64'(1));
            chk("stall_addr", 64'(flush_addr_out), 64'(7));
            chk("stall_data", 64'(flush_data_out), 64'h0000000077AA55CC);
            tick();
        end
        chk("accept_cycle_valid", 64'(flush_valid), 64'(1));
        flush_ready = 1'b1;
        tick();
        chk("valid_drops_after_accept", 64'(flush_valid), 64'(0));
        n = 0;
        while (!flush_done && n < 100) begin tick(); n++; end
        chk("done_seen", 64'(flush_done), 64'(1));
        chk("busy_during_done", 64'(busy), 64'(1));
        tick();
        chk("busy_after_done", 64'(busy), 64'(0));
        chk("done_single_pulse", 64'(flush_done), 64'(0));

        // Reset during EMIT aborts the scan and drops dirty state.
        cpu_wr(5'd20, 32'h20202020, 4'b1111);
        flush_ready = 1'b0;
        flush_start = 1'b1;
        tick();
        flush_start = 1'b0;
        n = 0;
        while (!flush_valid && n < 100) begin tick(); n++; end
        chk("emit20_addr", 64'(flush_addr_out), 64'(20));
        chk("emit20_data", 64'(flush_data_out), 64'h0000000020202020);
        tick();
        d0 = n_done;
        reset_n = 1'b0;
        #1;
        chk("abort_flush_valid", 64'(flush_valid), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_data_valid", 64'(data_valid), 64'(0));
        tick(); tick();
        reset_n = 1'b1;
        tick();
        chk("abort_no_done", 64'(n_done - d0), 64'(0));
        flush_ready = 1'b1;
        b0 = n_beats;
        run_scan(n);
        chk("post_reset_scan_cycles", 64'(n), 64'(34));
        chk("post_reset_scan_beats", 64'(n_beats - b0), 64'(0));
        chk("post_reset_done_pulses", 64'(n_done - d0), 64'(1));

        // Parity.
        cpu_wr(5'd10, 32'h12345678, 4'b1111);
`ifdef DCACHE_PARITY_EN
        u_dut.g_bank[2].u_bank.mem[10][0] = ~u_dut.g_bank[2].u_bank.mem[10][0];
        cpu_rd(5'd10, 32'h12355678, 1'b1);
        cpu_rd(5'd3, 32'hDEADBEAA, 1'b0);
`else
        cpu_rd(5'd10, 32'h12345678, 1'b0);
`endif

        tick(); tick();
        chk("read_queue_drained", 64'(rd_q.size()), 64'(0));
        chk("flush_queue_drained", 64'(fl_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
